// File: rtl/half_subtractor.sv
// Multi-lane registered half subtractor with a saturating count of
// accepted results that produced any borrow.
module half_subtractor #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic [WIDTH-1:0] diff,
   output logic [WIDTH-1:0] borrow,
   output logic             out_valid,
   output logic             borrow_any,
   output logic [CNT_W-1:0] borrow_cnt
);

   logic [WIDTH-1:0] diff_d, diff_q;
   logic [WIDTH-1:0] borrow_d, borrow_q;
   logic             any_d, any_q;
   logic             valid_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      diff_d   = a ^ b;
      borrow_d = ~a & b;
      any_d    = |borrow_d;
      cnt_d    = cnt_q;
      // Stop at all-ones so the count never wraps back to zero.
      if (in_valid && any_d && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         diff_q   <= '0;
         borrow_q <= '0;
         any_q    <= 1'b0;
         valid_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         valid_q <= in_valid;
         cnt_q   <= cnt_d;
         if (in_valid) begin
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            any_q    <= any_d;
         end
      end
   end

   assign diff       = diff_q;
   assign borrow     = borrow_q;
   assign borrow_any = any_q;
   assign out_valid  = valid_q;
   assign borrow_cnt = cnt_q;

endmodule

// File: tb/tb_half_subtractor.sv
// Bench for half_subtractor: a 4-lane/16-bit-count instance and a
// 1-lane/2-bit-count instance, both checked against an arithmetic model.
module tb_half_subtractor;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] a, b;
   logic       in_valid;
   logic       sa, sb;

   logic [3:0]  w_diff, w_borrow;
   logic        w_valid, w_any;
   logic [15:0] w_cnt;
   logic        s_diff, s_borrow, s_valid, s_any;
   logic [1:0]  s_cnt;

   int total = 0;
   int bad   = 0;

   // Model state
   logic [3:0]  m_diff, m_borrow;
   logic        m_valid, m_any;
   int          m_cnt;
   logic        ms_diff, ms_borrow, ms_valid, ms_any;
   int          ms_cnt;

   always #5 clk = ~clk;

   half_subtractor #(.WIDTH(4), .CNT_W(16)) u_wide (
      .clk        (clk),
      .rst        (rst),
      .a          (a),
      .b          (b),
      .in_valid   (in_valid),
      .diff       (w_diff),
      .borrow     (w_borrow),
      .out_valid  (w_valid),
      .borrow_any (w_any),
      .borrow_cnt (w_cnt)
   );

   half_subtractor #(.WIDTH(1), .CNT_W(2)) u_small (
      .clk        (clk),
      .rst        (rst),
      .a          (sa),
      .b          (sb),
      .in_valid   (in_valid),
      .diff       (s_diff),
      .borrow     (s_borrow),
      .out_valid  (s_valid),
      .borrow_any (s_any),
      .borrow_cnt (s_cnt)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of stimulus, advance the model, compare both instances.
   // The 1-lane instance sees lane 0 of a/b.
   task automatic step(input logic [3:0] av, input logic [3:0] bv, input logic v, input logic r);
      int d;
      a = av; b = bv; sa = av[0]; sb = bv[0]; in_valid = v; rst = r;
      @(posedge clk);
      #1;
      if (r) begin
         m_diff = '0; m_borrow = '0; m_any = 0; m_valid = 0; m_cnt = 0;
         ms_diff = 0; ms_borrow = 0; ms_any = 0; ms_valid = 0; ms_cnt = 0;
      end else if (v) begin
         for (int i = 0; i < 4; i++) begin
            d = int'(av[i]) - int'(bv[i]);
            m_diff[i]   = (d != 0);
            m_borrow[i] = (d < 0);
         end
         m_any   = (m_borrow != 4'd0);
         m_valid = 1'b1;
         if (m_any && m_cnt < 65535) m_cnt++;
         d         = int'(av[0]) - int'(bv[0]);
         ms_diff   = (d != 0);
         ms_borrow = (d < 0);
         ms_any    = ms_borrow;
         ms_valid  = 1'b1;
         if (ms_any && ms_cnt < 3) ms_cnt++;
      end else begin
         m_valid  = 1'b0;
         ms_valid = 1'b0;
      end
      check_eq("w_diff",   64'(w_diff),   64'(m_diff));
      check_eq("w_borrow", 64'(w_borrow), 64'(m_borrow));
      check_eq("w_any",    64'(w_any),    64'(m_any));
      check_eq("w_valid",  64'(w_valid),  64'(m_valid));
      check_eq("w_cnt",    64'(w_cnt),    64'(m_cnt));
      check_eq("s_diff",   64'(s_diff),   64'(ms_diff));
      check_eq("s_borrow", 64'(s_borrow), 64'(ms_borrow));
      check_eq("s_any",    64'(s_any),    64'(ms_any));
      check_eq("s_valid",  64'(s_valid),  64'(ms_valid));
      check_eq("s_cnt",    64'(s_cnt),    64'(ms_cnt));
   endtask

   initial begin
      logic [1:0] ex_d [4];
      int         sat_exp [5];
      ex_d    = '{2'b00, 2'b11, 2'b10, 2'b00};
      sat_exp = '{1, 2, 3, 3, 3};

      a = '0; b = '0; sa = 0; sb = 0; in_valid = 0; rst = 1;
      step(4'h0, 4'h0, 1'b0, 1'b1);
      step(4'h0, 4'h0, 1'b0, 1'b1);
      check_eq("rst_cnt", 64'(s_cnt), 64'd0);
      check_eq("rst_valid", 64'(w_valid), 64'd0);

      // 1-lane exhaustive truth table, back-to-back accepts
      for (int i = 0; i < 4; i++) begin
         step({3'b000, i[1]}, {3'b000, i[0]}, 1'b1, 1'b0);
         check_eq("ex_diff",   64'(s_diff),   64'(ex_d[i][1]));
         check_eq("ex_borrow", 64'(s_borrow), 64'(ex_d[i][0]));
         check_eq("ex_valid",  64'(s_valid),  64'd1);
      end
      check_eq("ex_cnt", 64'(s_cnt), 64'd1);

      // Hold with changed inputs
      step(4'hf, 4'h0, 1'b0, 1'b0);
      check_eq("hold_diff",  64'(s_diff),  64'd0);
      check_eq("hold_valid", 64'(s_valid), 64'd0);
      check_eq("hold_cnt",   64'(s_cnt),   64'd1);

      // 4-lane vector
      step(4'b0101, 4'b0011, 1'b1, 1'b0);
      check_eq("w4_diff",   64'(w_diff),   64'b0110);
      check_eq("w4_borrow", 64'(w_borrow), 64'b0010);
      check_eq("w4_any",    64'(w_any),    64'd1);

      // Reset wins over a borrowing accept
      step(4'h0, 4'h1, 1'b1, 1'b1);
      check_eq("rp_borrow", 64'(s_borrow), 64'd0);
      check_eq("rp_any",    64'(w_any),    64'd0);
      check_eq("rp_valid",  64'(s_valid),  64'd0);
      check_eq("rp_cnt",    64'(w_cnt),    64'd0);

      // Saturation of the 2-bit counter
      for (int i = 0; i < 5; i++) begin
         step(4'h0, 4'h1, 1'b1, 1'b0);
         check_eq("sat_cnt", 64'(s_cnt), 64'(sat_exp[i]));
      end

      for (int i = 0; i < 1000; i++) begin
         step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/half_subtractor.md
HALF_SUBTRACTOR -- requirements
Module: half_subtractor

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the number of independent half-subtract lanes (legal range 1..64).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the borrow event counter.

Interface
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  minuend bits, one per lane.
REQ-006 b  input  WIDTH  subtrahend bits, one per lane.
REQ-007 in_valid  input  1  a and b are valid this cycle.
REQ-008 diff  output  WIDTH  registered per-lane difference.
REQ-009 borrow  output  WIDTH  registered per-lane borrow-out.
REQ-010 out_valid  output  1  diff and borrow hold a new result.
REQ-011 borrow_any  output  1  registered OR of all borrow bits of the current result.
REQ-012 borrow_cnt  output  CNT_W  saturating count of accepted cycles with borrow_any set.

Function
REQ-013 For each lane i: diff[i] SHALL equal a[i] XOR b[i].
REQ-014 For each lane i: borrow[i] SHALL equal (NOT a[i]) AND b[i].
REQ-015 Per-lane truth table (a,b -> diff,borrow) SHALL be: 00->0,0; 01->1,1; 10->1,0; 11->0,0.
REQ-016 Lanes SHALL be fully independent; no borrow SHALL propagate between lanes.
REQ-017 Latency SHALL be exactly one clock: when in_valid=1 at edge N, the results SHALL appear on diff, borrow, borrow_any at edge N and out_valid SHALL be 1 in the following cycle.
REQ-018 When in_valid=0 at an edge, diff, borrow and borrow_any SHALL hold their previous values and out_valid SHALL be 0 in the following cycle.
REQ-019 out_valid SHALL be a single-cycle-per-accept pulse; back-to-back in_valid SHALL give back-to-back out_valid with no bubbles.
REQ-020 The block SHALL have no backpressure; every input presented with in_valid=1 SHALL be accepted.
REQ-021 borrow_cnt SHALL increment by 1 at each accepting edge whose computed borrow is nonzero.
REQ-022 borrow_cnt SHALL saturate at 2^CNT_W-1 and SHALL not wrap.
REQ-023 Outputs SHALL be driven only from registers; no combinational path from inputs to outputs.

Reset
REQ-024 While rst=1 at a rising edge, diff, borrow, borrow_any, out_valid and borrow_cnt SHALL all become 0.
REQ-025 rst SHALL take priority over in_valid at the same edge; the input is discarded and not counted.
REQ-026 The first edge with rst=0 SHALL process inputs normally.
REQ-027 Before the first reset, output values are unspecified; the bench SHALL assert rst for at least one edge before checking.

Verification
REQ-028 WIDTH=1 exhaustive: apply (a,b)=00,01,10,11 with in_valid=1 on consecutive edges -> the next cycles show (diff,borrow)=00, 11, 10, 00; out_valid=1 on all four cycles; borrow_cnt=1.
REQ-029 Hold: set in_valid=0 and change a/b -> diff/borrow unchanged, out_valid=0, borrow_cnt unchanged.
REQ-030 WIDTH=4: a=4'b0101, b=4'b0011 -> diff=4'b0110, borrow=4'b0010, borrow_any=1.
REQ-031 Reset priority: rst=1 with in_valid=1, a=0, b=1 -> all outputs 0 at the next cycle, borrow_cnt=0.
REQ-032 Saturation: CNT_W=2, apply a=0, b=1 for 5 accepted cycles -> borrow_cnt reads 1,2,3,3,3.
REQ-033 Random: 1000 random a/b/in_valid vectors compared against the REQ-013/014 model, delayed one cycle -> zero mismatches.
